// File: rtl/carry_select_adder_pkg.sv
// Shared defaults for the carry-select adder slice.
package carry_select_adder_pkg;

    localparam int unsigned CsaDefaultWidth = 4;
    localparam int unsigned CsaDefaultBlock = 2;

endpackage

// File: rtl/csa_ripple_block.sv
// Parameterised ripple-carry adder used as the building block of the carry-select adder.
module csa_ripple_block #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];

endmodule

// File: rtl/carry_select_adder.sv
// Carry-select adder with registered sum/carry: block 0 ripples from cin, each higher
// block precomputes both carry-in cases and muxes on the previous block's carry.
module carry_select_adder
    import carry_select_adder_pkg::*;
#(
    parameter int unsigned WIDTH = CsaDefaultWidth,
    parameter int unsigned BLOCK = CsaDefaultBlock
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned NumBlk = WIDTH / BLOCK;

    if (WIDTH < 2 || BLOCK == 0 || (WIDTH % BLOCK) != 0) begin : gen_param_check
        $error("carry_select_adder: WIDTH must be >= 2 and a multiple of BLOCK");
    end

    // Unpacked so each block-boundary carry is its own net.
    logic             c [NumBlk+1];
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    assign c[0] = cin;

    csa_ripple_block #(
        .W (BLOCK)
    ) u_blk0 (
        .a    (a[BLOCK-1:0]),
        .b    (b[BLOCK-1:0]),
        .cin  (c[0]),
        .sum  (sum_d[BLOCK-1:0]),
        .cout (c[1])
    );

    for (genvar k = 1; k < NumBlk; k++) begin : gen_blk
        logic [BLOCK-1:0] s0, s1;
        logic             co0, co1;

        csa_ripple_block #(
            .W (BLOCK)
        ) u_rc0 (
            .a    (a[k*BLOCK +: BLOCK]),
            .b    (b[k*BLOCK +: BLOCK]),
            .cin  (1'b0),
            .sum  (s0),
            .cout (co0)
        );

        csa_ripple_block #(
            .W (BLOCK)
        ) u_rc1 (
            .a    (a[k*BLOCK +: BLOCK]),
            .b    (b[k*BLOCK +: BLOCK]),
            .cin  (1'b1),
            .sum  (s1),
            .cout (co1)
        );

        assign sum_d[k*BLOCK +: BLOCK] = c[k] ? s1 : s0;
        assign c[k+1]                  = c[k] ? co1 : co0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= c[NumBlk];
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench for carry_select_adder (4-bit/2-bit blocks and 8-bit/4-bit blocks).
module tb_carry_select_adder;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       carry;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] a4, b4, sum4;
    logic       cin4, carry4;
    logic [7:0] a8, b8, sum8;
    logic       cin8, carry8;

    int nchecks;
    int nerrors;

    carry_select_adder #(
        .WIDTH (4),
        .BLOCK (2)
    ) dut4 (
        .clk   (clk),
        .rst   (rst),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .sum   (sum4),
        .carry (carry4)
    );

    carry_select_adder #(
        .WIDTH (8),
        .BLOCK (4)
    ) dut8 (
        .clk   (clk),
        .rst   (rst),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8),
        .carry (carry8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got carry,sum=%h required %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0, c};
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + {8'b0, c};
    endfunction

    vec_t       vecs [8];
    logic [4:0] exp4;
    logic [8:0] exp8;

    initial begin
        nchecks = 0;
        nerrors = 0;
        // Hand-computed vectors; last two cover full propagation and block-1 selection.
        vecs[0] = '{4'h1, 4'h1, 1'b0, 4'b0010, 1'b0};
        vecs[1] = '{4'h2, 4'h3, 1'b0, 4'b0101, 1'b0};
        vecs[2] = '{4'h5, 4'h5, 1'b1, 4'b1011, 1'b0};
        vecs[3] = '{4'hF, 4'h1, 1'b1, 4'b0001, 1'b1};
        vecs[4] = '{4'hA, 4'hC, 1'b0, 4'b0110, 1'b1};
        vecs[5] = '{4'h6, 4'h9, 1'b1, 4'b0000, 1'b1};
        vecs[6] = '{4'hF, 4'h0, 1'b1, 4'b0000, 1'b1};
        vecs[7] = '{4'h7, 4'h0, 1'b1, 4'b1000, 1'b0};

        rst  = 1'b1;
        a4   = 4'hF;
        b4   = 4'hF;
        cin4 = 1'b1;
        a8   = 8'hFF;
        b8   = 8'hFF;
        cin8 = 1'b1;

        tick();
        check("reset_cycle1", {4'b0, carry4, sum4}, 9'h000);
        check("reset_cycle1_w8", {carry8, sum8}, 9'h000);
        tick();
        check("reset_cycle2", {4'b0, carry4, sum4}, 9'h000);
        rst = 1'b0;
        tick();
        check("first_after_reset_all_ones", {4'b0, carry4, sum4}, 9'h01F);
        check("first_after_reset_w8_all_ones", {carry8, sum8}, 9'h1FF);

        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b1;
        tick();
        check("zero_zero_cin", {4'b0, carry4, sum4}, 9'h001);

        for (int i = 0; i < 8; i++) begin
            a4   = vecs[i].a;
            b4   = vecs[i].b;
            cin4 = vecs[i].cin;
            tick();
            check($sformatf("vec%0d", i), {4'b0, carry4, sum4},
                  {4'b0, vecs[i].carry, vecs[i].sum});
        end

        // Back-to-back: new operands every cycle, each result checked the next cycle.
        for (int i = 0; i < 16; i++) begin
            a4   = 4'(i * 5 + 3);
            b4   = 4'(15 - i);
            cin4 = i[0];
            exp4 = model4(a4, b4, cin4);
            tick();
            check($sformatf("b2b%0d", i), {4'b0, carry4, sum4}, {4'b0, exp4});
        end

        // Mid-stream reset discards the in-flight operation.
        a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0;
        tick();
        check("pre_reset_op", {4'b0, carry4, sum4}, 9'h005);
        rst = 1'b1;
        a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0;
        tick();
        check("mid_reset", {4'b0, carry4, sum4}, 9'h000);
        rst = 1'b0;
        a4 = 4'h4; b4 = 4'h4; cin4 = 1'b1;
        tick();
        check("post_reset_op", {4'b0, carry4, sum4}, 9'h009);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            iv   = 9'(i);
            a4   = iv[3:0];
            b4   = iv[7:4];
            cin4 = iv[8];
            exp4 = model4(a4, b4, cin4);
            tick();
            check($sformatf("exh_a%h_b%h_c%0d", iv[3:0], iv[7:4], iv[8]),
                  {4'b0, carry4, sum4}, {4'b0, exp4});
        end

        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        tick();
        check("w8_full_propagate", {carry8, sum8}, 9'h100);
        a8 = 8'h0F; b8 = 8'h00; cin8 = 1'b1;
        tick();
        check("w8_block_select", {carry8, sum8}, 9'h010);

        for (int i = 0; i < 10000; i++) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            exp8 = model8(a8, b8, cin8);
            tick();
            check("w8_random", {carry8, sum8}, exp8);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- Parameterised carry-select adder with registered outputs. Computes a + b + cin.
- The operand is split into equal blocks:
  - Block 0 ripples with the true carry-in.
  - Each higher block precomputes results for carry-in 0 and carry-in 1, then a mux picks one using the previous block's carry.
- Used as a low-latency arithmetic leaf inside datapaths; one clock, one-cycle latency.

Parameters:
- WIDTH, 4, operand/sum width in bits (>= 2).
- BLOCK, 2, bits per carry-select block. WIDTH % BLOCK must be 0, else elaboration-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered low WIDTH bits of a+b+cin.
- carry  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Arithmetic: full result R = a + b + cin, computed at WIDTH+1 bits, unsigned. sum = R[WIDTH-1:0]; carry = R[WIDTH]. No overflow flag, no signed interpretation.
- Latency: exactly 1 cycle. Inputs are sampled at posedge N; the result is visible after posedge N. No input registers and no handshake; a new operation is accepted every cycle.
- Reset: on a posedge with rst=1, sum is cleared to 0 and carry to 0, regardless of a/b/cin. Reset has priority.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result appears on the first posedge after rst deasserts, using inputs present at that edge.
- Structure (required, not just functionally equivalent):
  - Block 0 (bits BLOCK-1:0) is a single ripple-carry adder fed by cin.
  - Each block k >= 1 holds two ripple-carry adders, one with carry-in tied 0 and one with carry-in tied 1.
  - A 2:1 mux, selected by c[k] (block k-1 carry-out), chooses that block's sum bits and carry-out.
  - The final block's selected carry-out is carry.
- The combinational path from inputs to the output registers is purely combinational: no latches and no internal state besides the output registers.
- Boundary cases:
  - All-ones + all-ones + cin=1 gives sum = all-ones, carry = 1.
  - Zero + zero + cin=1 gives sum = 1, carry = 0.
  - A carry that propagates through every block (e.g. F+0+1) must give the correct result within one cycle.
- X on inputs: no requirement beyond simulation propagation. Outputs are never X after reset.

Decomposition:
- No shared package needed. No typedefs; the WIDTH/BLOCK legality check lives in the top module.
- One natural sub-module: csa_ripple_block, a parameterised (W) ripple-carry adder with ports a, b, cin, sum, cout. It is instantiated once for block 0 and twice per higher block via generate.
- Muxes and output registers are in the top module.

Test Plan:
- Reset check: rst=1 for 2 cycles with a=F, b=F, cin=1 -> sum=0000, carry=0 while in reset. After release, next edge gives sum=1111, carry=1.
- Directed vectors (WIDTH=4, checked one cycle after apply):
  - 1+1+0 -> 0010/0
  - 2+3+0 -> 0101/0
  - 5+5+1 -> 1011/0
  - F+1+1 -> 0001/1
  - A+C+0 -> 0110/1
  - 6+9+1 -> 0000/1
- Full propagation through all blocks: F+0+1 -> 0000/1. Then 7+0+1 -> 1000/0, which exercises carry selection into block 1.
- Back-to-back throughput: change inputs every cycle for 16 cycles. Each output must match the previous cycle's inputs, with no bubbles.
- Mid-stream reset: assert rst for one cycle between two valid operations. Outputs are 0 that cycle, and the following operation is correct.
- Exhaustive: all 512 combinations of a, b, cin for WIDTH=4/BLOCK=2, and also WIDTH=8/BLOCK=4 (random 10k). Compare against a behavioural model of a+b+cin with one-cycle delay.
